// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache in front of a byte-wide data memory.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module data_cache #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       busywait,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_writedata,
  input  logic [7:0] mem_readdata,
  input  logic       mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
  localparam int NB = 1 << INDEX_BITS;
  localparam int BPB = 1 << OFFSET_BITS;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
  state_t state;
  logic [7:0] data_arr [NB][BPB];
  logic [TAG_BITS-1:0] tag_arr [NB];
  logic [NB-1:0] valid, dirty;
  logic [TAG_BITS-1:0] a_tag, req_tag;
  logic [INDEX_BITS-1:0] a_idx, req_idx;
  logic [OFFSET_BITS-1:0] a_off, k, k_nxt;
  logic gap, access, hit, xfer, byte_done;
  assign a_tag = address[7 -: TAG_BITS];
  assign a_idx = address[OFFSET_BITS +: INDEX_BITS];
  assign a_off = address[OFFSET_BITS-1:0];
  assign access = read ^ write;
  assign hit = valid[a_idx] && tag_arr[a_idx] == a_tag;
  assign busywait = (state != IDLE) | (access & ~hit);
  assign readdata = hit ? data_arr[a_idx][a_off] : 8'h00;
  assign k_nxt = k + 1'b1;
  assign xfer = state == WRITEBACK || state == ALLOCATE;
  assign byte_done = xfer && !gap && !mem_busywait;
  // Each byte: REQ phase (strobe high) until memory is idle, then one GAP cycle so the next strobe is a fresh edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      k <= '0;
      gap <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_writedata <= '0;
      req_tag <= '0;
      req_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && hit && write) dirty[a_idx] <= 1'b1;
          else if (access && !hit) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            k <= '0;
            gap <= 1'b0;
            valid[a_idx] <= 1'b0;
            if (valid[a_idx] && dirty[a_idx]) begin
              state <= WRITEBACK;
              mem_write <= 1'b1;
              mem_address <= {tag_arr[a_idx], a_idx, {OFFSET_BITS{1'b0}}};
              mem_writedata <= data_arr[a_idx][0];
            end else begin
              state <= ALLOCATE;
              mem_read <= 1'b1;
              mem_address <= {a_tag, a_idx, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK, ALLOCATE: begin
          if (byte_done) begin
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            gap <= 1'b1;
          end else if (gap) begin
            gap <= 1'b0;
            k <= k_nxt;
            if (&k) begin
              state <= state == WRITEBACK ? ALLOCATE : UPDATE;
              mem_read <= state == WRITEBACK;
              mem_address <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
            end else begin
              mem_read <= state == ALLOCATE;
              mem_write <= state == WRITEBACK;
              mem_address <= {mem_address[7:OFFSET_BITS], k_nxt};
              mem_writedata <= data_arr[req_idx][k_nxt];
            end
          end
        end
        UPDATE: begin
          valid[req_idx] <= 1'b1;
          dirty[req_idx] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Line storage is intentionally not reset; valid bits guard it.
  always_ff @(posedge clock) begin
    if (state == IDLE && access && write && hit) data_arr[a_idx][a_off] <= writedata;
    if (state == ALLOCATE && byte_done) data_arr[req_idx][k] <= mem_readdata;
    if (state == UPDATE) tag_arr[req_idx] <= req_tag;
  end
`ifdef DCACHE_STATS_EN
  logic after_update;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      after_update <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      after_update <= state == UPDATE;
      if (state == IDLE && access && hit && !after_update && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == IDLE && access && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized bench for data_cache against an architectural memory view and line-state model.
module tb_data_cache;
  logic clock = 0, reset = 0, read = 0, write = 0;
  logic [7:0] address = 0, writedata = 0, readdata, mem_address, mem_writedata;
  logic [7:0] mem_readdata = 0;
  logic busywait, mem_read, mem_write;
  logic mem_busywait = 0;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  data_cache dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #50 clock = ~clock;

  typedef logic [16:0] txn_t;
  txn_t got_q[$], exp_q[$];
  logic [7:0] mem [256];
  logic [7:0] view [256];
  bit m_valid [8], m_dirty [8];
  logic [2:0] m_tag [8];
  int m_hits = 0, m_misses = 0;
  int n_cmp = 0, n_bad = 0, both_hi = 0;

  // Memory: strobe edge raises busy, 40 units later the byte is transferred.
  always @(posedge mem_read or posedge mem_write) begin
    mem_busywait = 1;
    #40;
    if (mem_write) begin
      mem[mem_address] = mem_writedata;
      got_q.push_back({1'b1, mem_address, mem_writedata});
    end else if (mem_read) begin
      mem_readdata = mem[mem_address];
      got_q.push_back({1'b0, mem_address, 8'h00});
    end
    mem_busywait = 0;
  end
  always @(negedge clock) if (mem_read && mem_write) both_hi++;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    for (int i = 0; i < 256; i++) view[i] = mem[i];
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic run_access(input bit w, input logic [7:0] a, input logic [7:0] d);
    int idx, busy;
    bit exp_hit, ok;
    logic [2:0] t;
    logic [7:0] rd, exp_rd, va;
    bit tr[$];
    int pos[$];
    idx = int'(a[4:2]);
    t = a[7:5];
    exp_hit = m_valid[idx] && m_tag[idx] == t;
    exp_q.delete();
    got_q.delete();
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int k = 0; k < 4; k++) begin
          va = {m_tag[idx], idx[2:0], k[1:0]};
          exp_q.push_back({1'b1, va, view[va]});
        end
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, t, idx[2:0], k[1:0], 8'h00});
      m_valid[idx] = 1;
      m_tag[idx] = t;
      m_dirty[idx] = 0;
      m_misses++;
    end else m_hits++;
    exp_rd = view[a];
    if (w) begin
      view[a] = d;
      m_dirty[idx] = 1;
    end
    read = !w;
    write = w;
    address = a;
    writedata = d;
    busy = 0;
    @(negedge clock);
    while (busywait && busy < 100) begin
      tr.push_back(mem_read | mem_write);
      busy++;
      @(negedge clock);
    end
    rd = readdata;
    @(posedge clock);
    #1;
    read = 0;
    write = 0;
    n_cmp++;
    if (busy >= 100 || (busy != 0) == exp_hit) begin
      $display("FAIL stall a=%h w=%0d: busy cycles %0d, expected hit=%0d", a, w, busy, exp_hit);
      n_bad++;
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL txn_count a=%h: got %0d want %0d", a, got_q.size(), exp_q.size());
      n_bad++;
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          $display("FAIL txn[%0d] a=%h: got %h want %h", i, a, got_q[i], exp_q[i]);
          n_bad++;
        end
      end
    if (!w) begin
      n_cmp++;
      if (rd !== exp_rd) begin
        $display("FAIL readdata a=%h: got %h want %h", a, rd, exp_rd);
        n_bad++;
      end
    end
    foreach (tr[i]) if (tr[i]) pos.push_back(i);
    ok = pos.size() == exp_q.size();
    for (int i = 0; i + 1 < pos.size(); i++) if (pos[i+1] - pos[i] != 2) ok = 0;
    n_cmp++;
    if (!ok) begin
      $display("FAIL strobe_gap a=%h: %0d strobe cycles, want %0d spaced by 2", a, pos.size(), exp_q.size());
      n_bad++;
    end
  endtask

  task automatic test_reset();
    #5 reset = 1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if ({mem_read, mem_write, mem_address, mem_writedata, busywait} !== 19'd0) begin
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h bw=%b want all 0", mem_read, mem_write, mem_address, mem_writedata, busywait);
      n_bad++;
    end
    address = 8'h25;
    read = 1;
    #1;
    n_cmp++;
    if (busywait !== 1'b1 || readdata !== 8'h00) begin
      $display("FAIL reset_invalid: got bw=%b rd=%h want bw=1 rd=00", busywait, readdata);
      n_bad++;
    end
    read = 0;
    @(posedge clock);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_directed();
    run_access(0, 8'h25, 8'h00);
    run_access(0, 8'h26, 8'h00);
    run_access(1, 8'h25, 8'hAB);
    run_access(0, 8'h45, 8'h00);
    n_cmp++;
    if (mem[8'h25] !== 8'hAB) begin
      $display("FAIL evict_data: mem[25] got %h want ab", mem[8'h25]);
      n_bad++;
    end
  endtask

  task automatic test_noop();
    int strobes;
    got_q.delete();
    strobes = 0;
    read = 1;
    write = 1;
    address = 8'h10;
    @(negedge clock);
    n_cmp++;
    if (busywait !== 1'b0) begin
      $display("FAIL noop_busy: got %b want 0", busywait);
      n_bad++;
    end
    repeat (3) begin
      @(negedge clock);
      if (mem_read || mem_write) strobes++;
    end
    @(posedge clock);
    #1;
    read = 0;
    write = 0;
    n_cmp++;
    if (strobes != 0 || got_q.size() != 0) begin
      $display("FAIL noop_strobes: got %0d strobe cycles %0d txns want 0", strobes, got_q.size());
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int rises, cyc;
    bit prev;
    rises = 0;
    cyc = 0;
    prev = 0;
    read = 1;
    address = 8'h25;
    while (rises < 2 && cyc < 60) begin
      @(negedge clock);
      if (mem_read && !prev) rises++;
      prev = mem_read;
      cyc++;
    end
    n_cmp++;
    if (rises != 2) begin
      $display("FAIL fill_start: got %0d read strobes want 2", rises);
      n_bad++;
    end
    reset = 1;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      $display("FAIL reset_strobes: got rd=%b wr=%b want 0", mem_read, mem_write);
      n_bad++;
    end
    read = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    run_access(0, 8'h25, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 80; i++) begin
      a = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
      run_access(1'($urandom), a, 8'($urandom));
    end
    n_cmp++;
    if (both_hi != 0) begin
      $display("FAIL both_strobes: got %0d cycles with both high want 0", both_hi);
      n_bad++;
    end
  endtask

  task automatic test_stats();
`ifdef DCACHE_STATS_EN
    n_cmp++;
    if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
      $display("FAIL stats: got hit=%0d miss=%0d want hit=%0d miss=%0d", hit_count, miss_count, m_hits, m_misses);
      n_bad++;
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_directed();
    test_noop();
    test_reset_mid_fill();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
